framebuffer_write_arbiter: RTL

// - Shares the single framebuffer write port (addr/data/en into framebuffer_master) between NUM_REQ pixel writers,
//   e.g. MCU link, sprite blitter, line renderer. Fair round-robin grant, valid/ready handshake per requester.
// - Drops out-of-range writes and counts them. Optional vsync-triggered clear engine wipes the buffer each frame.

---
 rtl/framebuffer_write_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/framebuffer_write_arbiter.sv
// Round-robin arbiter sharing one framebuffer write port among NUM_REQ writers.
// Define FB_ARB_CLEAR_EN to build the vsync-triggered frame clear engine.
module framebuffer_write_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int ADDR_W      = 19,
    parameter int DATA_W      = 4,
    parameter int FB_PIXELS   = 307200,
    parameter int CLEAR_COLOR = 0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        vsync,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [ADDR_W-1:0]           wr_addr,
    output logic [DATA_W-1:0]           wr_data,
    output logic                        wr_en,
    output logic                        clear_busy,
    output logic [15:0]                 drop_count
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_W:0] FB_LIMIT = (ADDR_W+1)'(FB_PIXELS);

    typedef enum logic {
        ARB,
        CLEAR
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   win;
    logic [PTR_W-1:0]   nxt_ptr;
    logic [NUM_REQ-1:0] grant;
    logic               found;
    logic               xfer;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic               in_range;

    // Scan from rr_ptr upward, wrapping, and take the first valid requester.
    always_comb begin
        grant = '0;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                win        = PTR_W'(idx);
            end
        end
    end

    assign req_ready = (state == ARB && !reset) ? grant : '0;
    assign xfer      = |req_ready;
    assign nxt_ptr   = (win == PTR_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
    assign sel_addr  = req_addr[win*ADDR_W +: ADDR_W];
    assign sel_data  = req_data[win*DATA_W +: DATA_W];
    assign in_range  = {1'b0, sel_addr} < FB_LIMIT;

`ifdef FB_ARB_CLEAR_EN
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(FB_PIXELS - 1);

    logic              vsync_q;
    logic [ADDR_W-1:0] clr_cnt;

    assign clear_busy = (state == CLEAR);
`else
    assign clear_busy = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ARB;
            rr_ptr     <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            drop_count <= '0;
`ifdef FB_ARB_CLEAR_EN
            vsync_q    <= 1'b1;
            clr_cnt    <= '0;
`endif
        end else begin
            wr_en <= 1'b0;
            if (xfer) begin
                rr_ptr <= nxt_ptr;
                if (in_range) begin
                    wr_en   <= 1'b1;
                    wr_addr <= sel_addr;
                    wr_data <= sel_data;
                end else if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
            end
`ifdef FB_ARB_CLEAR_EN
            vsync_q <= vsync;
            // Ready is forced low in CLEAR, so the port is never contended.
            if (state == CLEAR) begin
                wr_en   <= 1'b1;
                wr_addr <= clr_cnt;
                wr_data <= DATA_W'(CLEAR_COLOR);
                clr_cnt <= clr_cnt + 1'b1;
                if (clr_cnt == CLR_LAST) begin
                    state <= ARB;
                end
            end else if (vsync_q && !vsync) begin
                state   <= CLEAR;
                clr_cnt <= '0;
            end
`endif
        end
    end

endmodule
